// File: rtl/pccm_pkg.sv
// Shared definitions for the PCCM response path: field widths, response
// code values and the response-generator FSM state type.
package pccm_pkg;

  localparam int RSP_CODE_W = 3;
  localparam int RSP_PORT_W = 4;
  localparam int HOLD_CNT_W = 16;

  localparam logic [RSP_CODE_W-1:0] RSP_OK      = 3'd1;
  localparam logic [RSP_CODE_W-1:0] RSP_ERR     = 3'd2;
  localparam logic [RSP_CODE_W-1:0] RSP_TIMEOUT = 3'd3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/pccm_rsp_gen_if.sv
// Bundle between the PCCM command engine / software side and the response
// generator: event handshake in, PIO port value and status out.
interface pccm_rsp_gen_if;
  import pccm_pkg::*;

  logic                  evt_valid;
  logic [RSP_CODE_W-1:0] evt_code;
  logic                  evt_ready;
  logic [RSP_PORT_W-1:0] rsp_port;
  logic                  rsp_busy;
  logic                  rsp_ovf;
  logic                  ovf_clr;

  modport master (
    output evt_valid, evt_code, ovf_clr,
    input  evt_ready, rsp_port, rsp_busy, rsp_ovf
  );

  modport slave (
    input  evt_valid, evt_code, ovf_clr,
    output evt_ready, rsp_port, rsp_busy, rsp_ovf
  );

endinterface

// File: rtl/pccm_rsp_fifo.sv
// Small synchronous FIFO holding queued response codes. Pushes while full
// and pops while empty are ignored, so callers may present raw requests.
module pccm_rsp_fifo
  import pccm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [RSP_CODE_W-1:0]   wr_data,
  output logic [RSP_CODE_W-1:0]   rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [RSP_CODE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage write; entries are only ever read after being written.
  // NOTE: the storage array is deliberately left out of reset -- validity is
  // tracked by the pointers and count, and a reset array would cost a mux per bit.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  // NOTE: non-blocking assignments here so every register samples pre-edge
  // values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pccm_rsp_gen.sv
// PCCM response generator: queues response codes and shows each on the PIO
// port as {toggle, code}, holding it for at least HOLD_CYCLES clocks.
// Optional sticky overflow flag enabled by defining PCCM_RSP_OVF_EN.
module pccm_rsp_gen
  import pccm_pkg::*;
#(
  parameter int HOLD_CYCLES = 64,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  pccm_rsp_gen_if.slave     bus
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(HOLD_CYCLES - 1);

  rsp_state_e                   state_q, state_d;
  logic [HOLD_CNT_W-1:0]        cnt_q, cnt_d;
  logic [RSP_PORT_W-1:0]        port_q, port_d;
  logic                         pop;
  logic                         load;
  logic                         full;
  logic                         empty;
  logic [RSP_CODE_W-1:0]        head;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  logic                         unused_fifo_count;

  pccm_rsp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (bus.evt_valid),
    .pop     (pop),
    .wr_data (bus.evt_code),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  assign unused_fifo_count = ^fifo_count;
  assign bus.evt_ready     = !full;
  assign bus.rsp_port      = port_q;
  assign bus.rsp_busy      = (state_q == HOLD);

  // State, hold counter and displayed value registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      port_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      port_q  <= port_d;
    end
  end

  // Next-state logic: load the next code whenever idle or a hold window ends.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    port_d  = port_q;
    pop     = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: load = !empty;
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!empty) begin
          load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
    if (load) begin
      pop     = 1'b1;
      port_d  = {~port_q[RSP_PORT_W-1], head};
      cnt_d   = HOLD_LOAD;
      state_d = HOLD;
    end
  end

`ifdef PCCM_RSP_OVF_EN
  logic ovf_q;

  // Sticky overflow: a refused offer sets it and wins over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (bus.evt_valid && full) begin
      ovf_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.rsp_ovf = ovf_q;
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = bus.ovf_clr;
  assign bus.rsp_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_pccm_rsp_gen.sv
// Bench for pccm_rsp_gen: three instances (HOLD_CYCLES 4, 64 and 1) with a
// per-instance scoreboard of expected rsp_port values checked on each change.
module tb_pccm_rsp_gen;
  import pccm_pkg::*;

`ifdef PCCM_RSP_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  typedef struct {
    bit         rst_before;
    logic [2:0] code;
    logic [3:0] port;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pccm_rsp_gen_if b4();
  pccm_rsp_gen_if b64();
  pccm_rsp_gen_if b1();

  pccm_rsp_gen #(.HOLD_CYCLES(4),  .FIFO_DEPTH(4)) dut4  (.clk(clk), .reset(reset), .bus(b4.slave));
  pccm_rsp_gen #(.HOLD_CYCLES(64), .FIFO_DEPTH(4)) dut64 (.clk(clk), .reset(reset), .bus(b64.slave));
  pccm_rsp_gen #(.HOLD_CYCLES(1),  .FIFO_DEPTH(4)) dut1  (.clk(clk), .reset(reset), .bus(b1.slave));

  int checks = 0;
  int errors = 0;
  logic [3:0] q4[$];
  logic [3:0] q64[$];
  logic [3:0] q1[$];
  int emitted64 = 0;
  int emitted1  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_inputs();
    b4.evt_valid  = 1'b0;
    b64.evt_valid = 1'b0;
    b1.evt_valid  = 1'b0;
    b4.ovf_clr    = 1'b0;
    b64.ovf_clr   = 1'b0;
    b1.ovf_clr    = 1'b0;
  endtask

  task automatic do_reset();
    release_inputs();
    reset = 1'b1;
    q4.delete();
    q64.delete();
    q1.delete();
    emitted64 = 0;
    emitted1  = 0;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  // Offer one code for one clock; queue the expected port value if accepted.
  task automatic send(input int inst, input logic [2:0] code, input logic exp_rdy,
                      input logic [3:0] exp_port);
    logic rdy;
    case (inst)
      0:       begin b4.evt_valid  = 1'b1; b4.evt_code  = code; rdy = b4.evt_ready;  end
      1:       begin b64.evt_valid = 1'b1; b64.evt_code = code; rdy = b64.evt_ready; end
      default: begin b1.evt_valid  = 1'b1; b1.evt_code  = code; rdy = b1.evt_ready;  end
    endcase
    check("evt_ready", rdy, exp_rdy);
    if (exp_rdy) begin
      case (inst)
        0:       q4.push_back(exp_port);
        1:       q64.push_back(exp_port);
        default: q1.push_back(exp_port);
      endcase
    end
    step(1);
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    bit done;
    done = 0;
    while (!done && n < max_cycles) begin
      done = (q4.size() == 0) && (q64.size() == 0) && (q1.size() == 0) &&
             !b4.rsp_busy && !b64.rsp_busy && !b1.rsp_busy;
      if (!done) begin
        step(1);
        n++;
      end
    end
    check("drain_in_time", done, 1'b1);
  endtask

  // Scoreboard monitors: every change of rsp_port must match the queue head.
  logic [3:0] prev4, prev64, prev1;
  int run4, run64, run1;
  bit shown4, shown64, shown1;

  always @(negedge clk) begin
    if (reset) begin
      prev4 = '0; run4 = 0; shown4 = 0;
    end else if (b4.rsp_port !== prev4) begin
      if (shown4) check("hold4_min", run4 >= 4, 1'b1);
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL out4_unexpected: got %b expected no change from %b", b4.rsp_port, prev4);
      end else begin
        check("out4", b4.rsp_port, q4.pop_front());
      end
      prev4 = b4.rsp_port; run4 = 1; shown4 = 1;
    end else begin
      run4++;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      prev64 = '0; run64 = 0; shown64 = 0;
    end else if (b64.rsp_port !== prev64) begin
      if (shown64) check("hold64_min", run64 >= 64, 1'b1);
      if (q64.size() == 0) begin
        checks++; errors++;
        $display("FAIL out64_unexpected: got %b expected no change from %b", b64.rsp_port, prev64);
      end else begin
        check("out64", b64.rsp_port, q64.pop_front());
      end
      emitted64++;
      prev64 = b64.rsp_port; run64 = 1; shown64 = 1;
    end else begin
      run64++;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      prev1 = '0; run1 = 0; shown1 = 0;
    end else if (b1.rsp_port !== prev1) begin
      if (shown1) check("hold1_exact", run1, 1);
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL out1_unexpected: got %b expected no change from %b", b1.rsp_port, prev1);
      end else begin
        check("out1", b1.rsp_port, q1.pop_front());
      end
      emitted1++;
      prev1 = b1.rsp_port; run1 = 1; shown1 = 1;
    end else begin
      run1++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   busy_cnt;
    logic [3:0] exp_b2b;

    vecs[0] = '{1'b1, RSP_ERR,     4'b1010};
    vecs[1] = '{1'b0, RSP_ERR,     4'b0010};
    vecs[2] = '{1'b1, RSP_TIMEOUT, 4'b1011};
    vecs[3] = '{1'b0, 3'd0,        4'b0000};
    vecs[4] = '{1'b0, 3'd7,        4'b1111};
    vecs[5] = '{1'b0, 3'd5,        4'b0101};

    b4.evt_code = '0; b64.evt_code = '0; b1.evt_code = '0;
    release_inputs();
    reset = 1'b1;
    step(3);

    // Reset state.
    check("rst_port",  b4.rsp_port,  4'b0000);
    check("rst_busy",  b4.rsp_busy,  1'b0);
    check("rst_ready", b4.evt_ready, 1'b1);
    check("rst_ovf",   b64.rsp_ovf,  1'b0);
    reset = 1'b0;
    step(1);

    // Single event: no bypass, visible one edge after acceptance, busy 4 clocks.
    send(0, RSP_OK, 1'b1, 4'b1001);
    release_inputs();
    check("no_bypass", b4.rsp_port, 4'b0000);
    step(1);
    check("single_port", b4.rsp_port, 4'b1001);
    busy_cnt = b4.rsp_busy ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (b4.rsp_busy) busy_cnt++;
    end
    check("single_busy_len", busy_cnt, 4);
    check("single_idle_port", b4.rsp_port, 4'b1001);
    check("single_idle_busy", b4.rsp_busy, 1'b0);

    // Back-to-back: each code held exactly 4 clocks with no gap.
    do_reset();
    send(0, 3'd1, 1'b1, 4'b1001);
    send(0, 3'd2, 1'b1, 4'b0010);
    send(0, 3'd3, 1'b1, 4'b1011);
    release_inputs();
    for (int k = 3; k <= 13; k++) begin
      exp_b2b = (k < 6) ? 4'b1001 : (k < 10) ? 4'b0010 : 4'b1011;
      check("b2b_step", b4.rsp_port, exp_b2b);
      step(1);
    end
    check("b2b_end_busy", b4.rsp_busy, 1'b0);
    check("b2b_end_port", b4.rsp_port, 4'b1011);

    // Table vectors: duplicate codes and assorted code values.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].rst_before) begin
        release_inputs();
        wait_idle(200);
        do_reset();
      end
      send(0, vecs[i].code, 1'b1, vecs[i].port);
    end
    release_inputs();
    wait_idle(200);

    // Reset mid-hold with two codes queued.
    do_reset();
    send(0, 3'd1, 1'b1, 4'b1001);
    send(0, 3'd2, 1'b1, 4'b0010);
    send(0, 3'd3, 1'b1, 4'b1011);
    release_inputs();
    step(1);
    reset = 1'b1;
    q4.delete();
    #1;
    check("midrst_port",  b4.rsp_port,  4'b0000);
    check("midrst_busy",  b4.rsp_busy,  1'b0);
    check("midrst_ready", b4.evt_ready, 1'b1);
    step(2);
    reset = 1'b0;
    step(20);
    check("midrst_stale_port", b4.rsp_port, 4'b0000);
    check("midrst_stale_busy", b4.rsp_busy, 1'b0);

    // Overflow on the HOLD_CYCLES=64 instance.
    do_reset();
    send(1, 3'd1, 1'b1, 4'b1001);
    send(1, 3'd2, 1'b1, 4'b0010);
    send(1, 3'd3, 1'b1, 4'b1011);
    send(1, 3'd4, 1'b1, 4'b0100);
    send(1, 3'd5, 1'b1, 4'b1101);
    send(1, 3'd6, 1'b0, 4'b0000);
    check("ovf_set", b64.rsp_ovf, OVF_EXP);
    b64.evt_code = 3'd7;
    b64.ovf_clr  = 1'b1;
    check("ovf_still_full", b64.evt_ready, 1'b0);
    step(1);
    check("ovf_set_wins", b64.rsp_ovf, OVF_EXP);
    b64.evt_valid = 1'b0;
    step(1);
    check("ovf_cleared", b64.rsp_ovf, 1'b0);
    release_inputs();
    wait_idle(600);
    check("ovf_emitted", emitted64, 5);

    // Streaming with HOLD_CYCLES=1: order preserved, one code per clock.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      send(2, 3'(i % 8), 1'b1, {(i % 2 == 0), 3'(i % 8)});
    end
    release_inputs();
    wait_idle(100);
    check("stream_emitted", emitted1, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
